oled_init_sequencer: RTL and testbench
======================================

// Module: oled_init_sequencer
// PURPOSE
//  Upstream feeder for the OLED SPI byte transmitter. After reset it drives the panel
//  hardware reset pulse and waits for power-up. It then issues a fixed init command list
//  as bytes over a valid/ready handshake, with DC=0.
//  Afterwards it passes pixel bytes from the frame source to the transmitter, with DC=1.
//  Sits between the frame/pixel logic and the SPI transmitter in the top-level chip interface.
// PARAMETERS
//  RESET_CYCLES  16  clk cycles oled_res_n is held low after reset release (>=1)
//  WAIT_CYCLES   64  clk cycles after oled_res_n rises before the first command (>=1)
// PORTS
//  clk         in   1  system clock; all state on posedge
//  rst_n       in   1  asynchronous, active-low reset
//  tx_data     out  8  byte offered to SPI transmitter
//  tx_dc       out  1  DC sideband for tx_data; 0=command, 1=data; valid with tx_valid
//  tx_valid    out  1  tx_data/tx_dc valid
//  tx_ready    in   1  transmitter accepts byte this cycle (handshake = tx_valid & tx_ready)
//  tx_idle     in   1  transmitter has finished shifting all accepted bytes
//  oled_res_n  out  1  panel hardware reset, active low
//  pix_data    in   8  pixel byte from frame source
//  pix_valid   in   1  pix_data valid
//  pix_ready   out  1  pixel byte consumed this cycle
//  init_done   out  1  high once streaming state is reached
// BEHAVIOUR
//  Reset (async assert):
//   - state=RST_LO, counter=0, cmd index=0.
//   - oled_res_n=0, tx_valid=0, tx_dc=0, tx_data=0, pix_ready=0, init_done=0.
//  Command ROM, N_CMDS=8, sent in order: AE D5 80 A8 3F 8D 14 AF.
//  FSM:
//   - RST_LO: oled_res_n=0; counter increments each cycle.
//     At counter==RESET_CYCLES-1 -> RST_WAIT, counter=0.
//   - RST_WAIT: oled_res_n=1; counter increments.
//     At counter==WAIT_CYCLES-1 -> CMD, idx=0.
//   - CMD: tx_valid=1, tx_dc=0, tx_data=ROM[idx]. On handshake idx++.
//     Handshake with idx==N_CMDS-1 -> DRAIN.
//     tx_data/tx_dc are held stable while tx_valid & !tx_ready.
//   - DRAIN: tx_valid=0; waits for tx_idle==1, then -> STREAM.
//     This guarantees the last command is fully shifted before DC flips.
//   - STREAM: terminal state; init_done=1, oled_res_n=1.
//     Combinational passthrough: tx_valid=pix_valid, tx_data=pix_data, tx_dc=1, pix_ready=tx_ready.
//     No pixel byte is dropped or duplicated.
//  Timing and outputs:
//   - oled_res_n, init_done and the FSM state are registered.
//   - In CMD, tx_data and tx_dc are decoded from registered state and idx only (no input paths).
//   - Counter width: $clog2(max(RESET_CYCLES,WAIT_CYCLES)+1). Index width: 3 bits.
//   - pix_ready=0 in every state except STREAM. Pixel input is ignored before STREAM.
//   - First command byte is offered exactly RESET_CYCLES+WAIT_CYCLES cycles after rst_n deasserts.
//  Boundary cases:
//   - tx_ready held low in CMD: stall indefinitely with the same byte; idx does not move.
//   - tx_ready high every cycle: one command per cycle; 8 cycles from CMD entry to DRAIN.
//   - tx_idle already high on DRAIN entry: STREAM on the next cycle.
//   - tx_idle/tx_ready toggling outside CMD/DRAIN/STREAM: no effect.
//   - rst_n asserted mid-operation (any state, including mid-handshake): immediate return to reset values.
//     The sequence restarts from RST_LO; partial command lists are never resumed.
// TESTING
//  1. Release reset, tx_ready=1, tx_idle=1:
//     - oled_res_n low for 16 cycles, high for 64.
//     - Then bytes AE,D5,80,A8,3F,8D,14,AF on 8 consecutive cycles, all with tx_dc=0.
//     - init_done=1 two cycles after AF is accepted (DRAIN, then STREAM).
//  2. Backpressure: tx_ready=0 for 5 cycles while D5 is offered.
//     - tx_data stays D5 and idx holds; D5 is accepted once tx_ready rises; next byte is 80.
//  3. Drain: tx_idle=0 for 10 cycles after AF is accepted.
//     - tx_valid=0 and init_done=0 throughout; STREAM is entered the cycle after tx_idle=1.
//  4. Stream: pix_data=0x55, pix_valid=1, tx_ready alternating 1/0.
//     - tx_dc=1, tx_data=0x55; pix_ready mirrors tx_ready.
//     - Number of pixel handshakes equals number of tx handshakes.
//  5. Reset mid-CMD after 3 bytes are sent:
//     - Outputs return to reset values immediately (oled_res_n=0, tx_valid=0).
//     - After release, a full 16/64 wait is followed by AE again.
//  6. pix_valid=1 during RST_LO, RST_WAIT and CMD: pix_ready stays 0 and no pixel byte appears on tx_data.

Source files
------------

// File: rtl/oled_init_sequencer.sv
// OLED panel bring-up: hardware reset pulse, power-up wait, fixed init command list
// (DC=0), then a pass-through of pixel bytes to the SPI transmitter (DC=1).
module oled_init_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int WAIT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic       oled_res_n,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       init_done
);

    localparam int MAX_CYCLES = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [2:0]       LAST_CMD  = 3'd7;

    localparam logic [2:0] RST_LO   = 3'd0;
    localparam logic [2:0] RST_WAIT = 3'd1;
    localparam logic [2:0] CMD      = 3'd2;
    localparam logic [2:0] DRAIN    = 3'd3;
    localparam logic [2:0] STREAM   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       idx;

    // Panel init list: display off, clock div, mux ratio 64, charge pump on, display on.
    function automatic logic [7:0] cmd_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'hAE;
            3'd1:    b = 8'hD5;
            3'd2:    b = 8'h80;
            3'd3:    b = 8'hA8;
            3'd4:    b = 8'h3F;
            3'd5:    b = 8'h8D;
            3'd6:    b = 8'h14;
            default: b = 8'hAF;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_LO;
            counter    <= '0;
            idx        <= '0;
            oled_res_n <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                RST_LO: begin
                    if (counter == RST_LAST) begin
                        state      <= RST_WAIT;
                        counter    <= '0;
                        oled_res_n <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (counter == WAIT_LAST) begin
                        state   <= CMD;
                        counter <= '0;
                        idx     <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                // tx_valid is always high here, so tx_ready alone marks the handshake
                CMD: begin
                    if (tx_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_CMD) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (tx_idle) begin
                        state     <= STREAM;
                        init_done <= 1'b1;
                    end
                end
                STREAM: begin
                    state <= STREAM;
                end
                default: begin
                    state      <= RST_LO;
                    counter    <= '0;
                    idx        <= '0;
                    oled_res_n <= 1'b0;
                    init_done  <= 1'b0;
                end
            endcase
        end
    end

    // Command bytes come from registered state only; pixels bypass straight through.
    always_comb begin
        tx_valid  = 1'b0;
        tx_dc     = 1'b0;
        tx_data   = 8'h00;
        pix_ready = 1'b0;
        case (state)
            CMD: begin
                tx_valid = 1'b1;
                tx_data  = cmd_byte(idx);
            end
            STREAM: begin
                tx_valid  = pix_valid;
                tx_data   = pix_data;
                tx_dc     = 1'b1;
                pix_ready = tx_ready;
            end
            default: begin
                tx_valid  = 1'b0;
                pix_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Scoreboard bench for oled_init_sequencer: stimulus pushes expected tx bytes,
// a negedge monitor pops and compares them on every tx handshake.
module tb_oled_init_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_idle;
    logic       oled_res_n;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       init_done;

    int total;
    int bad;
    int pix_hs;
    int tx_data_hs;
    int exp_pix;

    logic [8:0] exp_q[$];
    logic [7:0] cmd_list[8];

    oled_init_sequencer #(
        .RESET_CYCLES(16),
        .WAIT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_dc     (tx_dc),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_idle   (tx_idle),
        .oled_res_n(oled_res_n),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic rdy, input logic idle, input logic pv, input logic [7:0] pd);
        @(posedge clk);
        #1;
        tx_ready  = rdy;
        tx_idle   = idle;
        pix_valid = pv;
        pix_data  = pd;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " oled_res_n"}, 32'(oled_res_n), 32'h0);
        checkOutput({tag, " tx_valid"}, 32'(tx_valid), 32'h0);
        checkOutput({tag, " tx_dc"}, 32'(tx_dc), 32'h0);
        checkOutput({tag, " tx_data"}, 32'(tx_data), 32'h0);
        checkOutput({tag, " pix_ready"}, 32'(pix_ready), 32'h0);
        checkOutput({tag, " init_done"}, 32'(init_done), 32'h0);
    endtask

    task automatic pushCommands(input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({1'b0, cmd_list[i]});
        end
    endtask

    // Checks the 16-cycle low / 64-cycle high reset pulse and that nothing is offered meanwhile
    task automatic checkPowerUp(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput({tag, " res_lo oled_res_n"}, 32'(oled_res_n), 32'h0);
            checkOutput({tag, " res_lo tx_valid"}, 32'(tx_valid), 32'h0);
            checkOutput({tag, " res_lo pix_ready"}, 32'(pix_ready), 32'h0);
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checkOutput({tag, " wait oled_res_n"}, 32'(oled_res_n), 32'h1);
            checkOutput({tag, " wait tx_valid"}, 32'(tx_valid), 32'h0);
            checkOutput({tag, " wait pix_ready"}, 32'(pix_ready), 32'h0);
        end
    endtask

    // Monitor: every tx handshake must match the head of the scoreboard
    always @(negedge clk) begin
        logic [8:0] exp_item;
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_byte: got dc=%0b data=%0h, scoreboard empty", tx_dc, tx_data);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("sb tx_data", 32'(tx_data), 32'(exp_item[7:0]));
                checkOutput("sb tx_dc", 32'(tx_dc), 32'(exp_item[8]));
            end
            if (tx_dc) tx_data_hs++;
        end
        if (rst_n && pix_valid && pix_ready) pix_hs++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic rdy;
        total      = 0;
        bad        = 0;
        pix_hs     = 0;
        tx_data_hs = 0;
        exp_pix    = 0;
        cmd_list   = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF};

        // Full bring-up with stray pixel traffic before streaming
        rst_n     = 1'b0;
        tx_ready  = 1'b1;
        tx_idle   = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'hCC;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        @(negedge clk);
        checkReset("por");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        rst_n = 1'b1;
        exp_q.delete();
        pushCommands(8);
        checkPowerUp("A");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("A cmd tx_valid", 32'(tx_valid), 32'h1);
            checkOutput("A cmd tx_dc", 32'(tx_dc), 32'h0);
            checkOutput("A cmd pix_ready", 32'(pix_ready), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hCC);
        @(negedge clk);
        checkOutput("A drain tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("A drain init_done", 32'(init_done), 32'h0);
        @(negedge clk);
        checkOutput("A stream init_done", 32'(init_done), 32'h1);
        checkOutput("A stream oled_res_n", 32'(oled_res_n), 32'h1);
        checkOutput("A cmds consumed", 32'(exp_q.size()), 32'h0);

        // Streaming with alternating transmitter backpressure
        pix_hs     = 0;
        tx_data_hs = 0;
        exp_pix    = 0;
        for (int i = 0; i < 10; i++) begin
            rdy = (i % 2 == 0);
            applyStimulus(rdy, 1'b1, 1'b1, 8'h55);
            if (rdy) begin
                exp_q.push_back({1'b1, 8'h55});
                exp_pix++;
            end
            @(negedge clk);
            checkOutput("S pix_ready", 32'(pix_ready), 32'(rdy));
            checkOutput("S tx_valid", 32'(tx_valid), 32'h1);
            checkOutput("S tx_dc", 32'(tx_dc), 32'h1);
            checkOutput("S tx_data", 32'(tx_data), 32'h55);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        @(negedge clk);
        checkOutput("S pixel handshakes", 32'(pix_hs), 32'(exp_pix));
        checkOutput("S tx handshakes", 32'(tx_data_hs), 32'(exp_pix));
        checkOutput("S pixels consumed", 32'(exp_q.size()), 32'h0);

        // Reset during streaming, then backpressure on D5 and reset after three bytes
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        rst_n = 1'b0;
        #1;
        checkReset("stream_rst");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        rst_n = 1'b1;
        exp_q.delete();
        pushCommands(3);
        repeat (80) applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        @(negedge clk);
        checkOutput("B first byte", 32'(tx_data), 32'hAE);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hCC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("B stall tx_data", 32'(tx_data), 32'hD5);
            checkOutput("B stall tx_valid", 32'(tx_valid), 32'h1);
            checkOutput("B stall pix_ready", 32'(pix_ready), 32'h0);
            if (i < 4) applyStimulus(1'b0, 1'b1, 1'b1, 8'hCC);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        @(negedge clk);
        checkOutput("B release tx_data", 32'(tx_data), 32'hD5);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        @(negedge clk);
        checkOutput("B next tx_data", 32'(tx_data), 32'h80);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC);
        rst_n = 1'b0;
        #1;
        checkReset("cmd_rst");
        checkOutput("B three cmds consumed", 32'(exp_q.size()), 32'h0);

        // Restart from scratch, then stall the drain on tx_idle
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hCC);
        rst_n = 1'b1;
        exp_q.delete();
        pushCommands(8);
        checkPowerUp("C");
        @(negedge clk);
        checkOutput("C restart first byte", 32'(tx_data), 32'hAE);
        repeat (7) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("C drain tx_valid", 32'(tx_valid), 32'h0);
            checkOutput("C drain init_done", 32'(init_done), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hCC);
        @(negedge clk);
        checkOutput("C idle seen init_done", 32'(init_done), 32'h0);
        @(negedge clk);
        checkOutput("C stream init_done", 32'(init_done), 32'h1);
        checkOutput("C stream tx_dc", 32'(tx_dc), 32'h1);
        checkOutput("C cmds consumed", 32'(exp_q.size()), 32'h0);

        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
